// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and constants for the two-requester APB master.
// Holds the FSM state encoding, requester count and default bus widths.
package apb_arb_pkg;

    localparam int NREQ       = 2;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_e;

endpackage

// File: rtl/apb_master_arb_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant.
// Ports: req_i (requests), last_i (last winner), gnt_o (one-hot), any_o.
module rr_arb2
    import apb_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic            last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            any_o
);

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin arbiter + APB master for two requesters.
// Ports: req_* (requests in), req_ack/rsp_* (handshake out),
//        p* (APB master side). Optional macro: APB_ARB_TIMEOUT_EN.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ack,
    output logic [NREQ-1:0]        rsp_done,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [ADDR_W-1:0]      paddr,
    output logic [DATA_W-1:0]      pwdata,
    input  logic [DATA_W-1:0]      prdata,
    input  logic                   pready
);

    state_e              state_q, state_d;
    // last_q is both the RR pointer and the owner of the current transfer.
    logic                last_q, last_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic                err_q, err_d;

    logic [NREQ-1:0]     gnt;
    logic                any_req;
    logic                xfer_ok;
    logic                abort;
    logic                grant_en;
    logic                sel;

    rr_arb2 u_arb (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (gnt),
        .any_o  (any_req)
    );

    assign xfer_ok  = (state_q == ACCESS) && pready;
    assign grant_en = any_req && ((state_q == IDLE) || xfer_ok);
    assign sel      = gnt[1];

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts consecutive stalled ACCESS cycles; cleared in any other state.
    always_comb begin
        cnt_d = '0;
        if ((state_q == ACCESS) && !pready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign abort = (state_q == ACCESS) && !pready &&
                   (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (pready) begin
                    state_d = any_req ? SETUP : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        psel    = (state_q == SETUP) || (state_q == ACCESS);
        penable = (state_q == ACCESS);
    end

    always_comb begin
        last_d   = last_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        ack_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;
        if (xfer_ok || abort) begin
            done_d = last_q ? 2'b10 : 2'b01;
            err_d  = abort;
            if (xfer_ok && !pwrite_q) begin
                rdata_d = prdata;
            end
        end
        if (grant_en) begin
            last_d   = sel;
            ack_d    = gnt;
            pwrite_d = sel ? req_write[1] : req_write[0];
            paddr_d  = sel ? req_addr[ADDR_W +: ADDR_W]
                           : req_addr[0 +: ADDR_W];
            pwdata_d = sel ? req_wdata[DATA_W +: DATA_W]
                           : req_wdata[0 +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= 1'b1;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            ack_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            last_q   <= last_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_rdata = rdata_q;
    assign req_ack   = ack_q;
    assign rsp_done  = done_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: scoreboard bench for apb_master_arb with a memory
// slave model; honours APB_ARB_TIMEOUT_EN the same way as the design.
`timescale 1ns/1ps
module tb_apb_master_arb;
    import apb_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid, req_write;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_ack, rsp_done;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            psel, penable, pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata, prdata;
    logic            pready;

    apb_master_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rsp_done  (rsp_done),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] rd;
        bit            err;
        int            gap;
        int            ack_lat;
        int            done_lat;
        int            icyc;
    } txn_t;

    txn_t stim_q[2][$];
    txn_t pend_q[2][$];
    txn_t out_q[2][$];

    logic [DW-1:0] mmem [4096];
    logic [DW-1:0] smem [4096];
    logic [DW-1:0] hold_rd = '0;
    bit            model_last = 1'b1;
    logic [AW-1:0] cur_a;
    logic [DW-1:0] cur_d;
    int            vecs = 0;
    int            errs = 0;
    int            cyc = 0;
    int            gapc[2];
    int            fixed_wait = 0;
    bit            hang = 1'b0;
    logic [1:0]    rv_smp = '0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rv_smp <= req_valid;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic bit busy();
        return (stim_q[0].size() != 0) || (stim_q[1].size() != 0) ||
               (pend_q[0].size() != 0) || (pend_q[1].size() != 0) ||
               (out_q[0].size() != 0) || (out_q[1].size() != 0) ||
               psel || (req_valid != 2'b00);
    endfunction

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (busy() && n < maxc) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("drain", 64'(busy()), 64'd0);
    endtask

    task automatic add(input int i, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit err,
                       input int gap, input int al, input int dl);
        txn_t t;
        t.w = w; t.a = a; t.d = d; t.rd = '0; t.err = err;
        t.gap = gap; t.ack_lat = al; t.done_lat = dl; t.icyc = 0;
        stim_q[i].push_back(t);
    endtask

    // Requesters: issue queued transactions, drop or replace on ack.
    initial begin
        txn_t t;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        gapc[0] = 0; gapc[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ack[i]) begin
                    req_valid[i] = 1'b0;
                    req_addr[i*AW +: AW] = AW'($urandom);
                    req_wdata[i*DW +: DW] = $urandom;
                    gapc[i] = 0;
                end
                if (!req_valid[i] && rst_n && stim_q[i].size() > 0) begin
                    if (gapc[i] >= stim_q[i][0].gap) begin
                        t = stim_q[i].pop_front();
                        if (t.w) mmem[t.a] = t.d;
                        else     t.rd = mmem[t.a];
                        t.icyc = cyc;
                        pend_q[i].push_back(t);
                        req_valid[i] = 1'b1;
                        req_write[i] = t.w;
                        req_addr[i*AW +: AW] = t.a;
                        req_wdata[i*DW +: DW] = t.d;
                    end else begin
                        gapc[i]++;
                    end
                end
            end
        end
    end

    // APB slave: memory with programmable wait states, junk when idle.
    initial begin
        int wcnt = 0;
        int wtgt = 0;
        pready = 1'b0;
        prdata = '0;
        forever begin
            @(negedge clk);
            if (psel && !penable) begin
                wcnt = 0;
                wtgt = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
            end
            if (psel && penable) begin
                if (!hang && wcnt == wtgt) begin
                    pready = 1'b1;
                    if (pwrite) begin
                        smem[paddr] = pwdata;
                        prdata = $urandom;
                    end else begin
                        prdata = smem[paddr];
                    end
                end else begin
                    pready = 1'b0;
                    prdata = $urandom;
                end
                wcnt++;
            end else begin
                pready = 1'($urandom_range(0, 1));
                prdata = $urandom;
            end
        end
    end

    // Monitor: grant order, SETUP contents, bus stability, responses.
    initial begin
        txn_t       t;
        bit         exp_g;
        logic [1:0] exp_oh;
        logic [DW-1:0] exp_rd;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (psel && penable) begin
                    chk("paddr_hold", 64'(paddr), 64'(cur_a));
                    chk("pwdata_hold", 64'(pwdata), 64'(cur_d));
                end
                for (int i = 0; i < 2; i++) begin
                    if (req_ack[i]) begin
                        exp_g = (rv_smp == 2'b11) ? !model_last
                                                  : (rv_smp == 2'b10);
                        exp_oh = exp_g ? 2'b10 : 2'b01;
                        chk("grant", 64'(req_ack), 64'(exp_oh));
                        model_last = exp_g;
                        chk("setup_phase", 64'({psel, penable}), 64'd2);
                        if (pend_q[i].size() == 0) begin
                            chk("spurious_ack", 64'(i + 1), 64'd0);
                        end else begin
                            t = pend_q[i].pop_front();
                            chk("paddr", 64'(paddr), 64'(t.a));
                            chk("pwrite", 64'(pwrite), 64'(t.w));
                            chk("pwdata", 64'(pwdata), 64'(t.d));
                            if (t.ack_lat >= 0)
                                chk("ack_lat", 64'(cyc - t.icyc),
                                    64'(t.ack_lat));
                            cur_a = t.a;
                            cur_d = t.d;
                            out_q[i].push_back(t);
                        end
                    end
                    if (rsp_done[i]) begin
                        if (out_q[i].size() == 0) begin
                            chk("spurious_done", 64'(i + 1), 64'd0);
                        end else begin
                            t = out_q[i].pop_front();
                            exp_rd = (t.w || t.err) ? hold_rd : t.rd;
                            chk("rdata", 64'(rsp_rdata), 64'(exp_rd));
                            chk("err", 64'(rsp_err), 64'(t.err));
                            if (t.err) chk("psel_after_abort",
                                           64'(psel), 64'd0);
                            if (t.done_lat >= 0)
                                chk("done_lat", 64'(cyc - t.icyc),
                                    64'(t.done_lat));
                            hold_rd = exp_rd;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ps_exp;
        logic [4:0] pe_exp;
        int n;
        for (int a = 0; a < 4096; a++) begin
            mmem[a] = 32'(a) * 32'h9E37_79B1 ^ 32'hC0FF_EE00;
            smem[a] = mmem[a];
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_pwrite", 64'(pwrite), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_ack", 64'(req_ack), 64'd0);
        chk("rst_done", 64'(rsp_done), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write, one wait state: check psel/penable cycle by cycle.
        fixed_wait = 1;
        add(0, 1'b1, 12'h010, 32'hA5A5_0001, 1'b0, 0, 1, 4);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!req_valid[0] && n < 10);
        chk("t1_issue", 64'(req_valid[0]), 64'd1);
        ps_exp = 5'b01110;
        pe_exp = 5'b01100;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            chk("t1_psel", 64'(psel), 64'(ps_exp[k]));
            chk("t1_penable", 64'(penable), 64'(pe_exp[k]));
        end
        wait_drain(50);

        // Zero-wait read from requester 1.
        fixed_wait = 0;
        smem[12'h004] = 32'hDEAD_BEEF;
        mmem[12'h004] = 32'hDEAD_BEEF;
        add(1, 1'b0, 12'h004, '0, 1'b0, 0, 1, 3);
        wait_drain(50);
        chk("t2_rdata", 64'(rsp_rdata), 64'h0000_0000_DEAD_BEEF);

        // Both requesters hold requests: 0,1,0,1 back to back.
        add(0, 1'b1, 12'h030, $urandom, 1'b0, 0, 1, 3);
        add(0, 1'b0, 12'h030, '0, 1'b0, 0, 4, 6);
        add(1, 1'b1, 12'h830, $urandom, 1'b0, 0, 3, 5);
        add(1, 1'b0, 12'h830, '0, 1'b0, 0, 4, 6);
        wait_drain(100);

`ifdef APB_ARB_TIMEOUT_EN
        hang = 1'b1;
        add(0, 1'b0, 12'h020, '0, 1'b1, 0, 1, TO + 2);
        wait_drain(100);
        hang = 1'b0;
`endif

        // Reset while stuck in ACCESS; transfer is dropped.
        hang = 1'b1;
        add(1, 1'b0, 12'h840, '0, 1'b0, 0, 1, -1);
        n = 0;
        while (!(psel && penable) && n < 20) begin
            @(negedge clk);
            n++;
        end
`ifdef APB_ARB_TIMEOUT_EN
        repeat (5) @(negedge clk);
`else
        repeat (100) @(negedge clk);
`endif
        chk("stuck_access", 64'({psel, penable}), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_psel", 64'(psel), 64'd0);
        chk("arst_penable", 64'(penable), 64'd0);
        chk("arst_done", 64'(rsp_done), 64'd0);
        req_valid = '0;
        for (int i = 0; i < 2; i++) begin
            stim_q[i].delete();
            pend_q[i].delete();
            out_q[i].delete();
        end
        hold_rd = '0;
        model_last = 1'b1;
        hang = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        add(0, 1'b0, 12'h050, '0, 1'b0, 0, 1, 3);
        add(1, 1'b0, 12'h850, '0, 1'b0, 0, 3, 5);
        wait_drain(50);

        // Randomized traffic with random wait states.
        fixed_wait = -1;
        for (int k = 0; k < 150; k++) begin
            for (int i = 0; i < 2; i++) begin
                add(i, 1'($urandom_range(0, 1)),
                    AW'((i << 11) | $urandom_range(0, 15)), $urandom,
                    1'b0,
                    ($urandom_range(0, 9) < 4) ? 0 : $urandom_range(1, 3),
                    -1, -1);
            end
        end
        wait_drain(20000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Two-requester APB master and arbiter for the timer IP register bus. It accepts single read/write requests from two internal requesters, for example a host bridge and a self-test/DMA engine, and grants them round-robin. It sequences each granted request through APB SETUP and ACCESS phases toward the timer's APB slave, then returns completion, read data and error status to the winning requester.

## Interface
- ADDR_W, 12, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, max ACCESS cycles without pready before abort (used only with APB_ARB_TIMEOUT_EN)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  request pending, bit i = requester i; held until req_ack[i]
- req_write  in  2  1 = write, 0 = read
- req_addr  in  2*ADDR_W  requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  requester i at [i*DATA_W +: DATA_W]
- req_ack  out  2  one-cycle pulse: request i accepted and latched
- rsp_done  out  2  one-cycle pulse: transfer i finished
- rsp_rdata  out  DATA_W  read data, valid with rsp_done
- rsp_err  out  1  transfer aborted by timeout, valid with rsp_done
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready

## Operation
- FSM states:
  - IDLE: psel=0, penable=0.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- IDLE: if any req_valid, grant g, latch write/addr/wdata of g into pwrite/paddr/pwdata, go to SETUP. req_ack[g]=1 during the SETUP cycle.
- SETUP always goes to ACCESS.
- ACCESS with pready=0: stay; paddr, pwrite and pwdata are stable.
- ACCESS with pready=1: next cycle rsp_done[g]=1. On a read, rsp_rdata <= prdata.
  - If any req_valid is sampled in that cycle, grant again and go directly to SETUP, so transfers run back-to-back with no IDLE cycle.
  - Otherwise go to IDLE.
- Arbitration:
  - Round-robin pointer last, reset to 1, so requester 0 wins the first tie.
  - Single request: that requester wins.
  - Both requesting: the requester other than last wins. last <= g on every grant.
- req_valid is sampled only in IDLE, or in ACCESS when pready=1. A requester sees req_ack at the end of SETUP and must drop or replace its request in the next cycle.
- prdata is sampled only in ACCESS with pready=1 and pwrite=0. On writes, rsp_rdata holds its previous value.
- pready is ignored outside ACCESS.

## Timing
- Reset values: psel, penable, pwrite, paddr, pwdata, req_ack, rsp_done, rsp_rdata, rsp_err are all 0; state IDLE; last=1.
- All outputs are registered.
- Minimum transfer: SETUP + 1 ACCESS cycle. rsp_done follows the cycle in which pready is sampled high.
- Latency: request in IDLE at cycle 0 → SETUP in cycle 1 → ACCESS in cycle 2. With 0 wait states rsp_done is high in cycle 3; each wait state adds 1 cycle.
- Reset mid-transfer: outputs clear asynchronously and the transfer is dropped. No rsp_done is issued.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - A counter counts consecutive ACCESS cycles with pready=0.
  - When the count reaches TIMEOUT, the next cycle has psel=0, penable=0, rsp_done[g]=1, rsp_err=1, and rsp_rdata is unchanged. The FSM then goes to IDLE, with no back-to-back grant.
  - rsp_err=0 on normal completion.
- APB_ARB_TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely, and rsp_err is tied to 0.

## Structure
- Shared package apb_arb_pkg holds:
  - FSM state typedef: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
  - Requester count constant NREQ=2.
  - Default ADDR_W and DATA_W.
- Sub-module rr_arb2: combinational grant from req_valid and last, producing a one-hot grant and an any-request flag. The pointer register lives in the parent.

## Test plan
- Write to requester 0 (addr 0x010, data 0xA5A5_0001), slave with 1 wait state → psel high in cycles 1–3, penable high in cycles 2–3, pwrite=1, paddr=0x010, req_ack[0] in cycle 1, rsp_done[0] in cycle 4.
- Read from requester 1 (addr 0x004), zero-wait slave returning 0xDEAD_BEEF → rsp_done[1] in cycle 3, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Both requesters hold req_valid for 4 transfers → grant order 0,1,0,1, each SETUP immediately after the previous ACCESS with pready, and no IDLE cycle between them.
- pready held low, TIMEOUT=16, macro defined → 16 ACCESS cycles, then psel=0, rsp_done[g]=1, rsp_err=1. Macro undefined → still in ACCESS after 100 cycles.
- rst_n asserted during ACCESS → psel, penable and rsp_done go to 0 immediately. After release, simultaneous requests grant requester 0 first.
